packet_serializer: RTL and testbench
====================================

PACKET_SERIALIZER -- requirements
Module: packet_serializer

Interface
REQ-001 Parameter PACKET_SIZE, default 8: number of bytes per packet.
REQ-002 Parameter DATA_WIDTH, default 64: AXI-Stream tdata width; SHALL equal 8*PACKET_SIZE.
REQ-003 i_clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 i_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 i_s_axis_tdata  input  DATA_WIDTH  packet payload; byte k = tdata[8k+7:8k].
REQ-006 i_s_axis_tvalid  input  1  upstream packet valid.
REQ-007 i_s_axis_tlast  input  1  end-of-packet marker; expected 1 on every beat.
REQ-008 o_s_axis_tready  output  1  block can accept a packet.
REQ-009 o_uart_data  output  8  byte to UART transmitter.
REQ-010 o_uart_valid  output  1  o_uart_data valid.
REQ-011 i_uart_ready  input  1  UART transmitter accepts byte this cycle.
REQ-012 o_frame_err  output  1  one-cycle pulse: accepted beat had tlast=0.

Function
REQ-013 Input beat accepted on a cycle with i_s_axis_tvalid && o_s_axis_tready; beat captured into a holding register.
REQ-014 Output byte transferred on a cycle with o_uart_valid && i_uart_ready.
REQ-015 FSM states: IDLE, SEND, (CSUM when REQ-029 enabled).
REQ-016 IDLE: o_s_axis_tready=1, o_uart_valid=0; on accept -> SEND, byte counter=0.
REQ-017 SEND: o_s_axis_tready=0; o_uart_valid=1; o_uart_data = byte[counter], LSB byte first.
REQ-018 First byte presented on the cycle after accept (1-cycle latency).
REQ-019 o_uart_data and o_uart_valid SHALL stay stable while i_uart_ready=0.
REQ-020 On transfer with counter<PACKET_SIZE-1: counter increments; next byte presented the next cycle.
REQ-021 On transfer with counter==PACKET_SIZE-1: -> IDLE (or CSUM), o_uart_valid=0 next cycle.
REQ-022 No new packet accepted until final byte transferred; back-to-back packets cost 1 idle cycle between last byte and next accept.
REQ-023 Counter width $clog2(PACKET_SIZE+1); no wrap beyond final byte index.
REQ-024 o_frame_err pulses 1 cycle after accept when i_s_axis_tlast=0; packet still serialized normally.
REQ-025 i_uart_ready asserted while o_uart_valid=0 has no effect.

Reset
REQ-026 While i_rst_n=0: state IDLE, counter 0, holding register 0, o_s_axis_tready=0, o_uart_valid=0, o_uart_data=0, o_frame_err=0.
REQ-027 o_s_axis_tready rises on the first clock edge after reset release.
REQ-028 Reset mid-packet discards remaining bytes; no partial byte emitted after release.

Configuration
REQ-029 Macro SERIALIZER_CHECKSUM_EN defined: after byte PACKET_SIZE-1, state CSUM presents XOR of all PACKET_SIZE payload bytes as one extra byte under the same handshake, then -> IDLE.
REQ-030 SERIALIZER_CHECKSUM_EN undefined: no CSUM state, no checksum logic, exactly PACKET_SIZE bytes per packet.

Structure
REQ-031 Shared package holds PACKET_SIZE/DATA_WIDTH defaults, FSM state encoding, and checksum XOR function.
REQ-032 Single flat module; no sub-module.

Verification
REQ-033 tdata=0x0807060504030201, tlast=1, i_uart_ready held 1 -> bytes 01..08 on 8 consecutive cycles starting 1 cycle after accept; tready low throughout, high again after.
REQ-034 Same packet, i_uart_ready toggled 1/0 each cycle -> byte 0x03 held stable across stall cycles; sequence unchanged, no duplicate or dropped bytes.
REQ-035 Two packets offered back-to-back (tvalid held) -> second accepted only after 8th byte of first transferred; 16 bytes in order.
REQ-036 Beat with tlast=0 -> o_frame_err single-cycle pulse; 8 bytes still emitted.
REQ-037 i_rst_n low after 3rd byte -> outputs 0 during reset; after release, next packet starts from its byte 0.
REQ-038 SERIALIZER_CHECKSUM_EN defined, tdata=0x0807060504030201 -> 9th byte 0x08 (XOR of 01..08).

Source files
------------

// File: rtl/packet_serializer_pkg.sv
// Shared definitions for the AXI-Stream to UART byte serializer.
// SERIALIZER_CHECKSUM_EN adds the trailing XOR checksum state.
package packet_serializer_pkg;

  localparam int PACKET_SIZE_DEF = 8;
  localparam int DATA_WIDTH_DEF  = 8 * PACKET_SIZE_DEF;
  localparam int CSUM_MAX_BYTES  = 64;

`ifdef SERIALIZER_CHECKSUM_EN
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_CSUM = 2'd2
  } state_t;
`else
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;
`endif

  // XOR of the low nbytes bytes; callers zero-extend their payload to the max width.
  function automatic logic [7:0] csum_xor(input logic [8*CSUM_MAX_BYTES-1:0] data,
                                          input int unsigned               nbytes);
    logic [7:0] acc;
    acc = '0;
    for (int unsigned k = 0; k < CSUM_MAX_BYTES; k++) begin
      if (k < nbytes) acc ^= data[8*k +: 8];
    end
    return acc;
  endfunction

endpackage

// File: rtl/packet_serializer_if.sv
// Handshake bundle between the stream source, the serializer and the UART transmitter.
// The slave modport is the serializer's view; master is the environment's view.
interface packet_serializer_if
  import packet_serializer_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) ();

  logic [DATA_WIDTH-1:0] i_s_axis_tdata;
  logic                  i_s_axis_tvalid;
  logic                  i_s_axis_tlast;
  logic                  o_s_axis_tready;
  logic [7:0]            o_uart_data;
  logic                  o_uart_valid;
  logic                  i_uart_ready;
  logic                  o_frame_err;

  modport slave (
    input  i_s_axis_tdata, i_s_axis_tvalid, i_s_axis_tlast, i_uart_ready,
    output o_s_axis_tready, o_uart_data, o_uart_valid, o_frame_err
  );

  modport master (
    output i_s_axis_tdata, i_s_axis_tvalid, i_s_axis_tlast, i_uart_ready,
    input  o_s_axis_tready, o_uart_data, o_uart_valid, o_frame_err
  );

endinterface

// File: rtl/packet_serializer.sv
// Captures one AXI-Stream beat and emits it LSB byte first over a valid/ready UART port.
// Defining SERIALIZER_CHECKSUM_EN appends an XOR-of-payload byte to every packet.
module packet_serializer
  import packet_serializer_pkg::*;
#(
  parameter int PACKET_SIZE = PACKET_SIZE_DEF,
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  packet_serializer_if.slave  bus
);

  localparam int                CNT_W    = $clog2(PACKET_SIZE + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PACKET_SIZE - 1);

  if (DATA_WIDTH != 8 * PACKET_SIZE) begin : g_width_check
    $error("packet_serializer: DATA_WIDTH must equal 8*PACKET_SIZE");
  end

  state_t                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [DATA_WIDTH-1:0] r_hold;
  logic                  r_tready;
  logic                  r_valid;
  logic [7:0]            r_data;
  logic                  r_ferr;

  logic                  w_accept;
  logic                  w_xfer;
  logic [CNT_W-1:0]      w_next_cnt;
  logic [7:0]            w_next_byte;

  assign w_accept    = bus.i_s_axis_tvalid && r_tready;
  assign w_xfer      = r_valid && bus.i_uart_ready;
  // Saturate at the final index so the byte select never reaches past the payload.
  assign w_next_cnt  = (r_cnt == LAST_IDX) ? r_cnt : r_cnt + CNT_W'(1);
  assign w_next_byte = r_hold[8*w_next_cnt +: 8];

`ifdef SERIALIZER_CHECKSUM_EN
  logic [7:0] w_csum;
  assign w_csum = csum_xor((8*CSUM_MAX_BYTES)'(r_hold), PACKET_SIZE);
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_hold   <= '0;
      r_tready <= 1'b0;
      r_valid  <= 1'b0;
      r_data   <= '0;
      r_ferr   <= 1'b0;
    end else begin
      r_ferr <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_tready <= 1'b1;
          r_valid  <= 1'b0;
          if (w_accept) begin
            r_hold   <= bus.i_s_axis_tdata;
            r_cnt    <= '0;
            r_data   <= bus.i_s_axis_tdata[7:0];
            r_valid  <= 1'b1;
            r_tready <= 1'b0;
            r_ferr   <= !bus.i_s_axis_tlast;
            r_state  <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (w_xfer) begin
            if (r_cnt == LAST_IDX) begin
`ifdef SERIALIZER_CHECKSUM_EN
              r_data   <= w_csum;
              r_state  <= ST_CSUM;
`else
              r_valid  <= 1'b0;
              r_tready <= 1'b1;
              r_state  <= ST_IDLE;
`endif
            end else begin
              r_cnt  <= w_next_cnt;
              r_data <= w_next_byte;
            end
          end
        end
`ifdef SERIALIZER_CHECKSUM_EN
        ST_CSUM: begin
          if (w_xfer) begin
            r_valid  <= 1'b0;
            r_tready <= 1'b1;
            r_state  <= ST_IDLE;
          end
        end
`endif
        default: begin
          r_valid  <= 1'b0;
          r_tready <= 1'b0;
          r_state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.o_s_axis_tready = r_tready;
  assign bus.o_uart_valid    = r_valid;
  assign bus.o_uart_data     = r_data;
  assign bus.o_frame_err     = r_ferr;

endmodule

// File: tb/tb_packet_serializer.sv
// Randomized bench for packet_serializer; expected byte streams come from a queue model.
// Honors SERIALIZER_CHECKSUM_EN the same way the design does.
module tb_packet_serializer;
  import packet_serializer_pkg::*;

  localparam int PS = 8;
  localparam int DW = 64;
`ifdef SERIALIZER_CHECKSUM_EN
  localparam int NB = PS + 1;
`else
  localparam int NB = PS;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  packet_serializer_if #(.DATA_WIDTH(DW)) bif ();

  packet_serializer #(.PACKET_SIZE(PS), .DATA_WIDTH(DW)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bif)
  );

  int checks = 0;
  int errors = 0;

  logic [63:0] q_data[$];
  bit          q_last[$];
  logic [7:0]  exp_q[$];
  logic [7:0]  got[$];
  int          got_cyc[$];
  int          acc_cyc[$];
  int          ferr_cyc[$];
  bit          trdy_h[$];
  bit          vld_h[$];
  logic [7:0]  dat_h[$];
  int          stall_viol;
  bit          timed_out;

  // Reference: bytes of a packet in transmit order, plus the XOR byte when enabled.
  function automatic void model_push(input logic [63:0] d);
    logic [7:0] b;
    logic [7:0] x;
    x = 8'h00;
    for (int k = 0; k < PS; k++) begin
      b = 8'((d >> (8 * k)) & 64'hFF);
      exp_q.push_back(b);
      x = x ^ b;
    end
`ifdef SERIALIZER_CHECKSUM_EN
    exp_q.push_back(x);
`endif
  endfunction

  function automatic logic [63:0] rand64();
    return {$urandom(), $urandom()};
  endfunction

  // Offers q_data packets and records everything observed, one cycle per iteration.
  task automatic run_traffic(input int ready_mode, input int gap_pct, input int max_cycles);
    int         pi, c, tail, total;
    bit         acc, gap, pv, pr;
    logic [7:0] pd;
    pi = 0; c = 0; tail = 0; pv = 0; pr = 0; pd = '0;
    total = q_data.size() * NB;
    got.delete(); got_cyc.delete(); acc_cyc.delete(); ferr_cyc.delete();
    trdy_h.delete(); vld_h.delete(); dat_h.delete();
    stall_viol = 0; timed_out = 0;
    while (1) begin
      gap = (gap_pct > 0) && (int'($urandom_range(99)) < gap_pct);
      if (pi < q_data.size() && !gap) begin
        bif.i_s_axis_tvalid = 1'b1;
        bif.i_s_axis_tdata  = q_data[pi];
        bif.i_s_axis_tlast  = q_last[pi];
      end else begin
        bif.i_s_axis_tvalid = 1'b0;
        bif.i_s_axis_tdata  = rand64();
        bif.i_s_axis_tlast  = 1'b0;
      end
      case (ready_mode)
        0:       bif.i_uart_ready = 1'b1;
        1:       bif.i_uart_ready = (c % 2 == 0);
        default: bif.i_uart_ready = ($urandom_range(3) != 0);
      endcase
      @(negedge clk);
      trdy_h.push_back(bif.o_s_axis_tready);
      vld_h.push_back(bif.o_uart_valid);
      dat_h.push_back(bif.o_uart_data);
      if (bif.o_frame_err) ferr_cyc.push_back(c);
      if (bif.o_uart_valid && bif.i_uart_ready) begin
        got.push_back(bif.o_uart_data);
        got_cyc.push_back(c);
      end
      if (pv && !pr && !(bif.o_uart_valid && bif.o_uart_data === pd)) stall_viol++;
      pv = bif.o_uart_valid; pr = bif.i_uart_ready; pd = bif.o_uart_data;
      acc = bif.i_s_axis_tvalid && bif.o_s_axis_tready;
      if (acc) acc_cyc.push_back(c);
      @(posedge clk); #1;
      if (acc) pi++;
      c++;
      if (pi == q_data.size() && got.size() >= total) tail++;
      if (tail > 4) break;
      if (c >= max_cycles) begin
        timed_out = 1'b1;
        break;
      end
    end
    bif.i_s_axis_tvalid = 1'b0;
    bif.i_uart_ready    = 1'b0;
  endtask

  task automatic test_reset();
    bif.i_s_axis_tvalid = 1'b0;
    bif.i_s_axis_tdata  = 64'h0;
    bif.i_s_axis_tlast  = 1'b0;
    bif.i_uart_ready    = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (bif.o_s_axis_tready !== 1'b0) begin errors++; $display("FAIL reset_tready: got %b expected 0", bif.o_s_axis_tready); end
    checks++; if (bif.o_uart_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bif.o_uart_valid); end
    checks++; if (bif.o_uart_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", bif.o_uart_data); end
    checks++; if (bif.o_frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b expected 0", bif.o_frame_err); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (bif.o_s_axis_tready !== 1'b0) begin errors++; $display("FAIL release_tready_before_edge: got %b expected 0", bif.o_s_axis_tready); end
    @(negedge clk);
    checks++; if (bif.o_s_axis_tready !== 1'b1) begin errors++; $display("FAIL release_tready_after_edge: got %b expected 1", bif.o_s_axis_tready); end
    checks++; if (bif.o_uart_valid !== 1'b0) begin errors++; $display("FAIL idle_valid: got %b expected 0", bif.o_uart_valid); end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int a;
    q_data = '{64'h0807060504030201}; q_last = '{1'b1};
    exp_q.delete(); model_push(q_data[0]);
    run_traffic(0, 0, 100);
    checks++; if (timed_out) begin errors++; $display("FAIL basic_timeout: got timeout expected completion"); end
    checks++; if (got.size() != NB || acc_cyc.size() != 1) begin
      errors++; $display("FAIL basic_count: got %0d bytes %0d accepts expected %0d bytes 1 accept", got.size(), acc_cyc.size(), NB);
    end else begin
      a = acc_cyc[0];
      for (int k = 0; k < NB; k++) begin
        checks++; if (got[k] !== exp_q[k]) begin errors++; $display("FAIL basic_byte%0d: got %h expected %h", k, got[k], exp_q[k]); end
        checks++; if (got_cyc[k] != a + 1 + k) begin errors++; $display("FAIL basic_cycle%0d: got %0d expected %0d", k, got_cyc[k], a + 1 + k); end
      end
      for (int k = a + 1; k <= a + NB; k++) begin
        checks++; if (trdy_h[k] !== 1'b0) begin errors++; $display("FAIL basic_tready_low_c%0d: got %b expected 0", k, trdy_h[k]); end
      end
      checks++; if (trdy_h[a + NB + 1] !== 1'b1) begin errors++; $display("FAIL basic_tready_high: got %b expected 1", trdy_h[a + NB + 1]); end
`ifdef SERIALIZER_CHECKSUM_EN
      checks++; if (got[PS] !== 8'h08) begin errors++; $display("FAIL basic_checksum: got %h expected 08", got[PS]); end
`endif
    end
  endtask

  task automatic test_stall();
    int hold03;
    q_data = '{64'h0807060504030201}; q_last = '{1'b1};
    exp_q.delete(); model_push(q_data[0]);
    run_traffic(1, 0, 200);
    checks++; if (timed_out) begin errors++; $display("FAIL stall_timeout: got timeout expected completion"); end
    checks++; if (got != exp_q) begin errors++; $display("FAIL stall_sequence: got %p expected %p", got, exp_q); end
    checks++; if (stall_viol != 0) begin errors++; $display("FAIL stall_stability: got %0d violations expected 0", stall_viol); end
    hold03 = 0;
    foreach (vld_h[i]) if (vld_h[i] && dat_h[i] === 8'h03) hold03++;
    checks++; if (hold03 < 2) begin errors++; $display("FAIL stall_hold03: got %0d cycles expected >=2", hold03); end
  endtask

  task automatic test_back_to_back();
    q_data = '{64'h0807060504030201, rand64()}; q_last = '{1'b1, 1'b1};
    exp_q.delete(); model_push(q_data[0]); model_push(q_data[1]);
    run_traffic(0, 0, 200);
    checks++; if (timed_out) begin errors++; $display("FAIL b2b_timeout: got timeout expected completion"); end
    checks++; if (got != exp_q) begin errors++; $display("FAIL b2b_sequence: got %p expected %p", got, exp_q); end
    checks++; if (acc_cyc.size() != 2) begin
      errors++; $display("FAIL b2b_accepts: got %0d expected 2", acc_cyc.size());
    end else begin
      checks++; if (acc_cyc[1] - acc_cyc[0] != NB + 1) begin
        errors++; $display("FAIL b2b_spacing: got %0d expected %0d", acc_cyc[1] - acc_cyc[0], NB + 1);
      end
    end
  endtask

  task automatic test_frame_err();
    q_data = '{rand64(), rand64()}; q_last = '{1'b0, 1'b1};
    exp_q.delete(); model_push(q_data[0]); model_push(q_data[1]);
    run_traffic(0, 0, 200);
    checks++; if (got != exp_q) begin errors++; $display("FAIL ferr_sequence: got %p expected %p", got, exp_q); end
    checks++; if (ferr_cyc.size() != 1 || acc_cyc.size() < 1) begin
      errors++; $display("FAIL ferr_pulses: got %0d expected 1", ferr_cyc.size());
    end else begin
      checks++; if (ferr_cyc[0] != acc_cyc[0] + 1) begin
        errors++; $display("FAIL ferr_timing: got cycle %0d expected %0d", ferr_cyc[0], acc_cyc[0] + 1);
      end
    end
  endtask

  task automatic test_reset_mid();
    int  n;
    bit  acc, reached;
    logic [63:0] b;
    n = 0; reached = 0;
    bif.i_s_axis_tvalid = 1'b1;
    bif.i_s_axis_tdata  = 64'h1122334455667788;
    bif.i_s_axis_tlast  = 1'b1;
    bif.i_uart_ready    = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      acc = bif.i_s_axis_tvalid && bif.o_s_axis_tready;
      if (bif.o_uart_valid && bif.i_uart_ready) n++;
      @(posedge clk); #1;
      if (acc) bif.i_s_axis_tvalid = 1'b0;
      if (n == 3) begin reached = 1; break; end
    end
    checks++; if (!reached) begin errors++; $display("FAIL rstmid_reach3: got %0d bytes expected 3", n); end
    rst_n = 1'b0;
    #1;
    checks++; if (bif.o_uart_valid !== 1'b0 || bif.o_uart_data !== 8'h00) begin
      errors++; $display("FAIL rstmid_async: got valid %b data %h expected 0 00", bif.o_uart_valid, bif.o_uart_data);
    end
    @(negedge clk);
    checks++; if (bif.o_s_axis_tready !== 1'b0 || bif.o_frame_err !== 1'b0) begin
      errors++; $display("FAIL rstmid_ctrl: got tready %b ferr %b expected 0 0", bif.o_s_axis_tready, bif.o_frame_err);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    b = rand64();
    q_data = '{b}; q_last = '{1'b1};
    exp_q.delete(); model_push(b);
    run_traffic(0, 0, 100);
    checks++; if (timed_out) begin errors++; $display("FAIL rstmid_timeout: got timeout expected completion"); end
    checks++; if (got != exp_q) begin errors++; $display("FAIL rstmid_sequence: got %p expected %p", got, exp_q); end
  endtask

  task automatic test_random();
    int j, nerr;
    q_data.delete(); q_last.delete(); exp_q.delete();
    nerr = 0;
    for (int i = 0; i < 20; i++) begin
      q_data.push_back(rand64());
      q_last.push_back($urandom_range(3) != 0);
      model_push(q_data[i]);
      if (!q_last[i]) nerr++;
    end
    run_traffic(2, 30, 4000);
    checks++; if (timed_out) begin errors++; $display("FAIL rand_timeout: got timeout expected completion"); end
    checks++; if (got != exp_q) begin errors++; $display("FAIL rand_sequence: got %0d bytes expected %0d bytes in order", got.size(), exp_q.size()); end
    checks++; if (stall_viol != 0) begin errors++; $display("FAIL rand_stability: got %0d violations expected 0", stall_viol); end
    checks++; if (acc_cyc.size() != 20) begin errors++; $display("FAIL rand_accepts: got %0d expected 20", acc_cyc.size()); end
    checks++; if (ferr_cyc.size() != nerr) begin
      errors++; $display("FAIL rand_ferr_count: got %0d expected %0d", ferr_cyc.size(), nerr);
    end else if (acc_cyc.size() == 20) begin
      j = 0;
      for (int i = 0; i < 20; i++) begin
        if (!q_last[i]) begin
          checks++; if (ferr_cyc[j] != acc_cyc[i] + 1) begin
            errors++; $display("FAIL rand_ferr_timing%0d: got %0d expected %0d", i, ferr_cyc[j], acc_cyc[i] + 1);
          end
          j++;
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_back_to_back();
    test_frame_err();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
